// File: rtl/sysbus_pkg.sv
// Shared types and constants for the system-bus interconnect: slave indices,
// address-region nibbles, FSM states and the error-completion data word.
package sysbus_pkg;

  localparam int unsigned ADDR_W = 32;
  localparam int unsigned MASK_W = 4;

  typedef enum logic [1:0] {
    SLV_DMEM  = 2'd0,
    SLV_GEMM  = 2'd1,
    SLV_PER   = 2'd2,
    SLV_SPARE = 2'd3
  } slv_idx_e;

  localparam logic [3:0] REGION_GEMM  = 4'h9;
  localparam logic [3:0] REGION_PER   = 4'hA;
  localparam logic [3:0] REGION_SPARE = 4'hB;

  typedef enum logic {
    IDLE = 1'b0,
    WAIT = 1'b1
  } state_e;

  localparam logic [31:0] BUS_ERR_DATA = 32'hDEAD_BEEF;

endpackage

// File: rtl/sysbus_addr_decode.sv
// Combinational region decode: top address nibble to slave one-hot and index.
// Regions mapping to a slave port that is not instantiated fall back to DMEM.
module sysbus_addr_decode
  import sysbus_pkg::*;
#(
  parameter int unsigned NUM_SLV = 4,
  parameter int unsigned SW      = (NUM_SLV > 1) ? $clog2(NUM_SLV) : 1
) (
  input  logic [3:0]         region,
  output logic [NUM_SLV-1:0] onehot,
  output logic [SW-1:0]      idx
);

  slv_idx_e slv;

  always_comb begin
    slv = SLV_DMEM;
    unique case (region)
      REGION_GEMM:  slv = SLV_GEMM;
      REGION_PER:   slv = SLV_PER;
      REGION_SPARE: slv = SLV_SPARE;
      default:      slv = SLV_DMEM;
    endcase
    if (32'(slv) >= NUM_SLV) slv = SLV_DMEM;
    idx         = SW'(slv);
    onehot      = '0;
    onehot[idx] = 1'b1;
  end

endmodule

// File: rtl/sysbus_interconnect.sv
// System-bus interconnect: decodes the master access to one slave, stalls until
// it responds and returns read data. Optional timeout via BUS_TIMEOUT_EN.
module sysbus_interconnect
  import sysbus_pkg::*;
#(
  parameter int unsigned         NUM_SLV    = 4,
  parameter int unsigned         DW         = 32,
  parameter logic [NUM_SLV-1:0]  FIXED_MASK = 4'b0011,
  parameter int unsigned         TIMEOUT    = 255
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  m_en,
  input  logic                  m_rdwr,
  input  logic [ADDR_W-1:0]     m_addr,
  input  logic [DW-1:0]         m_wr_data,
  input  logic [MASK_W-1:0]     m_mask,
  output logic [DW-1:0]         m_rd_data,
  output logic                  m_stall,
  output logic                  m_err,
  output logic [NUM_SLV-1:0]    s_en,
  output logic                  s_rdwr,
  output logic [ADDR_W-1:0]     s_addr,
  output logic [DW-1:0]         s_wr_data,
  output logic [MASK_W-1:0]     s_mask,
  input  logic [NUM_SLV*DW-1:0] s_rd_data,
  input  logic [NUM_SLV-1:0]    s_ready
);

  localparam int unsigned SW = (NUM_SLV > 1) ? $clog2(NUM_SLV) : 1;

  state_e               state, state_nx;
  logic [SW-1:0]        sel, sel_nx;
  logic [NUM_SLV-1:0]   dec_onehot;
  logic [SW-1:0]        dec_idx;
  logic                 rdy;
  logic                 issue;
  logic                 unused_addr_bits;

`ifdef BUS_TIMEOUT_EN
  localparam int unsigned CW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  logic [CW-1:0]        wait_cnt, wait_cnt_nx;
`endif

  sysbus_addr_decode #(
    .NUM_SLV (NUM_SLV),
    .SW      (SW)
  ) u_decode (
    .region (m_addr[31:28]),
    .onehot (dec_onehot),
    .idx    (dec_idx)
  );

  assign s_rdwr           = m_rdwr;
  assign s_addr           = {m_addr[31:2], 2'b00};
  assign s_wr_data        = m_wr_data;
  assign s_mask           = m_mask;
  assign unused_addr_bits = ^m_addr[1:0];

  // Fixed-latency slaves always answer one cycle after the strobe.
  assign rdy = FIXED_MASK[sel] | s_ready[sel];

  always_comb begin
    state_nx  = state;
    sel_nx    = sel;
    s_en      = '0;
    m_stall   = 1'b0;
    m_err     = 1'b0;
    m_rd_data = '0;
    issue     = 1'b0;
`ifdef BUS_TIMEOUT_EN
    wait_cnt_nx = wait_cnt;
`endif
    if (rst) begin
      unique case (state)
        IDLE: issue = m_en;
        WAIT: begin
          if (rdy) begin
            m_rd_data = s_rd_data[sel*DW +: DW];
            issue     = m_en;
            if (!m_en) state_nx = IDLE;
          end
`ifdef BUS_TIMEOUT_EN
          else if (wait_cnt == CW'(TIMEOUT)) begin
            m_err     = 1'b1;
            m_rd_data = DW'(BUS_ERR_DATA);
            issue     = m_en;
            if (!m_en) state_nx = IDLE;
          end
          else begin
            m_stall     = 1'b1;
            wait_cnt_nx = wait_cnt + CW'(1);
          end
`else
          else m_stall = 1'b1;
`endif
        end
        default: state_nx = IDLE;
      endcase
      // New access is strobed in the same cycle it is accepted.
      if (issue) begin
        s_en     = dec_onehot;
        sel_nx   = dec_idx;
        state_nx = WAIT;
`ifdef BUS_TIMEOUT_EN
        wait_cnt_nx = '0;
`endif
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state <= IDLE;
      sel   <= '0;
`ifdef BUS_TIMEOUT_EN
      wait_cnt <= '0;
`endif
    end else begin
      state <= state_nx;
      sel   <= sel_nx;
`ifdef BUS_TIMEOUT_EN
      wait_cnt <= wait_cnt_nx;
`endif
    end
  end

endmodule

// File: tb/tb_sysbus_interconnect.sv
// Self-checking bench for sysbus_interconnect: table of single accesses plus
// hand sequences for back-to-back, held request, reset mid-access and timeout.
module tb_sysbus_interconnect;
  import sysbus_pkg::*;

  localparam int unsigned NUM_SLV = 4;
  localparam int unsigned DW      = 32;
`ifdef BUS_TIMEOUT_EN
  localparam int unsigned TMO = 8;
`else
  localparam int unsigned TMO = 255;
`endif

  logic                  clk;
  logic                  rst;
  logic                  m_en;
  logic                  m_rdwr;
  logic [31:0]           m_addr;
  logic [DW-1:0]         m_wr_data;
  logic [3:0]            m_mask;
  logic [DW-1:0]         m_rd_data;
  logic                  m_stall;
  logic                  m_err;
  logic [NUM_SLV-1:0]    s_en;
  logic                  s_rdwr;
  logic [31:0]           s_addr;
  logic [DW-1:0]         s_wr_data;
  logic [3:0]            s_mask;
  logic [NUM_SLV*DW-1:0] s_rd_data;
  logic [NUM_SLV-1:0]    s_ready;

  sysbus_interconnect #(
    .NUM_SLV    (NUM_SLV),
    .DW         (DW),
    .FIXED_MASK (4'b0011),
    .TIMEOUT    (TMO)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .m_en      (m_en),
    .m_rdwr    (m_rdwr),
    .m_addr    (m_addr),
    .m_wr_data (m_wr_data),
    .m_mask    (m_mask),
    .m_rd_data (m_rd_data),
    .m_stall   (m_stall),
    .m_err     (m_err),
    .s_en      (s_en),
    .s_rdwr    (s_rdwr),
    .s_addr    (s_addr),
    .s_wr_data (s_wr_data),
    .s_mask    (s_mask),
    .s_rd_data (s_rd_data),
    .s_ready   (s_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  assign s_rd_data = {32'h4444_4444, 32'h3333_3333, 32'h2222_2222, 32'h1111_1111};

  typedef struct {
    logic        rdwr;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  mask;
    int          delay;
    logic [3:0]  sen;
    logic [31:0] saddr;
    logic [31:0] rdata;
  } vec_t;

  int errors = 0;
  int checks = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic next_cycle();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic drive(input logic en, input logic rdwr, input logic [31:0] addr);
    m_en   = en;
    m_rdwr = rdwr;
    m_addr = addr;
  endtask

  vec_t vecs[7];

  initial begin
    vecs[0] = '{1'b0, 32'h0000_0010, 32'h0,         4'h0, 1, 4'b0001, 32'h0000_0010, 32'h1111_1111};
    vecs[1] = '{1'b1, 32'h9000_0004, 32'hCAFE_F00D, 4'hF, 1, 4'b0010, 32'h9000_0004, 32'h2222_2222};
    vecs[2] = '{1'b0, 32'hA000_0000, 32'h0,         4'h0, 3, 4'b0100, 32'hA000_0000, 32'h3333_3333};
    vecs[3] = '{1'b0, 32'hB000_0013, 32'h0,         4'h3, 2, 4'b1000, 32'hB000_0010, 32'h4444_4444};
    vecs[4] = '{1'b0, 32'h8000_0007, 32'h0,         4'h1, 1, 4'b0001, 32'h8000_0004, 32'h1111_1111};
    vecs[5] = '{1'b0, 32'hC000_0000, 32'h0,         4'h0, 1, 4'b0001, 32'hC000_0000, 32'h1111_1111};
    vecs[6] = '{1'b1, 32'hA000_0008, 32'h1234_5678, 4'h6, 1, 4'b0100, 32'hA000_0008, 32'h3333_3333};

    rst = 1'b0; m_en = 1'b0; m_rdwr = 1'b0; m_addr = '0;
    m_wr_data = '0; m_mask = '0; s_ready = '0;
    @(negedge clk);
    #1;
    chk("reset m_stall",   32'(m_stall),   32'h0);
    chk("reset m_err",     32'(m_err),     32'h0);
    chk("reset s_en",      32'(s_en),      32'h0);
    chk("reset m_rd_data", m_rd_data,      32'h0);
    next_cycle();
    rst = 1'b1;
    #1;
    chk("post-reset m_stall", 32'(m_stall), 32'h0);

    // Table-driven single accesses.
    for (int i = 0; i < 7; i++) begin
      vec_t v;
      v = vecs[i];
      drive(1'b1, v.rdwr, v.addr);
      m_wr_data = v.wdata;
      m_mask    = v.mask;
      s_ready   = '0;
      #1;
      chk($sformatf("v%0d issue s_en", i),      32'(s_en),      32'(v.sen));
      chk($sformatf("v%0d issue s_addr", i),    s_addr,         v.saddr);
      chk($sformatf("v%0d issue s_rdwr", i),    32'(s_rdwr),    32'(v.rdwr));
      chk($sformatf("v%0d issue s_wr_data", i), s_wr_data,      v.wdata);
      chk($sformatf("v%0d issue s_mask", i),    32'(s_mask),    32'(v.mask));
      chk($sformatf("v%0d issue m_stall", i),   32'(m_stall),   32'h0);
      chk($sformatf("v%0d issue m_rd_data", i), m_rd_data,      32'h0);
      next_cycle();
      m_en = 1'b0;
      for (int j = 1; j < v.delay; j++) begin
        s_ready = ~v.sen;
        #1;
        chk($sformatf("v%0d wait%0d m_stall", i, j),   32'(m_stall), 32'h1);
        chk($sformatf("v%0d wait%0d s_en", i, j),      32'(s_en),    32'h0);
        chk($sformatf("v%0d wait%0d m_rd_data", i, j), m_rd_data,    32'h0);
        next_cycle();
      end
      s_ready = v.sen & 4'b1100;
      #1;
      chk($sformatf("v%0d resp m_stall", i),   32'(m_stall), 32'h0);
      chk($sformatf("v%0d resp m_rd_data", i), m_rd_data,    v.rdata);
      chk($sformatf("v%0d resp s_en", i),      32'(s_en),    32'h0);
      next_cycle();
      s_ready = 4'hF;
      #1;
      chk($sformatf("v%0d idle m_stall", i),   32'(m_stall), 32'h0);
      chk($sformatf("v%0d idle m_rd_data", i), m_rd_data,    32'h0);
      s_ready = '0;
    end

    // Back-to-back: GEMM read issued in the DMEM response cycle.
    drive(1'b1, 1'b0, 32'h0000_0000);
    #1;
    chk("b2b first s_en", 32'(s_en), 32'b0001);
    next_cycle();
    drive(1'b1, 1'b0, 32'h9000_0000);
    #1;
    chk("b2b resp1 m_rd_data", m_rd_data,    32'h1111_1111);
    chk("b2b second s_en",     32'(s_en),    32'b0010);
    chk("b2b resp1 m_stall",   32'(m_stall), 32'h0);
    next_cycle();
    m_en = 1'b0;
    #1;
    chk("b2b resp2 m_rd_data", m_rd_data,    32'h2222_2222);
    chk("b2b resp2 s_en",      32'(s_en),    32'h0);
    next_cycle();
    #1;
    chk("b2b idle m_rd_data", m_rd_data, 32'h0);

    // Held request during a stall is not re-issued.
    drive(1'b1, 1'b0, 32'hA000_0040);
    #1;
    chk("held issue s_en", 32'(s_en), 32'b0100);
    for (int j = 1; j < 3; j++) begin
      next_cycle();
      #1;
      chk($sformatf("held wait%0d s_en", j),    32'(s_en),    32'h0);
      chk($sformatf("held wait%0d m_stall", j), 32'(m_stall), 32'h1);
    end
    next_cycle();
    m_en    = 1'b0;
    s_ready = 4'b0100;
    #1;
    chk("held resp m_rd_data", m_rd_data, 32'h3333_3333);
    chk("held resp s_en",      32'(s_en), 32'h0);
    next_cycle();
    s_ready = '0;

    // Reset during a slave-2 wait drops the access.
    drive(1'b1, 1'b0, 32'hA000_0000);
    next_cycle();
    m_en = 1'b0;
    #1;
    chk("rstmid wait m_stall", 32'(m_stall), 32'h1);
    rst = 1'b0;
    drive(1'b1, 1'b0, 32'h0000_0000);
    #1;
    chk("rstmid m_stall",   32'(m_stall), 32'h0);
    chk("rstmid s_en",      32'(s_en),    32'h0);
    chk("rstmid m_rd_data", m_rd_data,    32'h0);
    chk("rstmid m_err",     32'(m_err),   32'h0);
    next_cycle();
    rst     = 1'b1;
    m_en    = 1'b0;
    s_ready = 4'b0100;
    #1;
    chk("late ready m_stall",   32'(m_stall), 32'h0);
    chk("late ready m_rd_data", m_rd_data,    32'h0);
    next_cycle();
    s_ready = '0;
    drive(1'b1, 1'b0, 32'h0000_0020);
    #1;
    chk("after rst s_en", 32'(s_en), 32'b0001);
    next_cycle();
    m_en = 1'b0;
    #1;
    chk("after rst m_rd_data", m_rd_data, 32'h1111_1111);
    next_cycle();

    // Slave 3 never ready.
    drive(1'b1, 1'b0, 32'hB000_0000);
    next_cycle();
    m_en = 1'b0;
`ifdef BUS_TIMEOUT_EN
    for (int j = 1; j <= 8; j++) begin
      #1;
      chk($sformatf("tmo wait%0d m_stall", j), 32'(m_stall), 32'h1);
      chk($sformatf("tmo wait%0d m_err", j),   32'(m_err),   32'h0);
      next_cycle();
    end
    #1;
    chk("tmo m_err",     32'(m_err),   32'h1);
    chk("tmo m_rd_data", m_rd_data,    32'hDEAD_BEEF);
    chk("tmo m_stall",   32'(m_stall), 32'h0);
    next_cycle();
    #1;
    chk("tmo idle m_err",     32'(m_err),   32'h0);
    chk("tmo idle m_stall",   32'(m_stall), 32'h0);
    chk("tmo idle m_rd_data", m_rd_data,    32'h0);
`else
    for (int j = 1; j <= 20; j++) begin
      #1;
      chk($sformatf("stuck wait%0d m_stall", j), 32'(m_stall), 32'h1);
      chk($sformatf("stuck wait%0d m_err", j),   32'(m_err),   32'h0);
      next_cycle();
    end
    s_ready = 4'b1000;
    #1;
    chk("stuck release m_rd_data", m_rd_data,    32'h4444_4444);
    chk("stuck release m_stall",   32'(m_stall), 32'h0);
    next_cycle();
    s_ready = '0;
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
